// File: rtl/seq_divider_pkg.sv
// Shared datapath definitions for the sequential divider and its control hooks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: divider state encoding, default operand width, and the ALU-select
// value the control unit uses to steer a divide into seq_divider.
package seq_divider_pkg;

    // Default operand / quotient / remainder width.
    localparam int DIV_WIDTH = 8;

    // The control unit decodes these encodings directly, so they are fixed.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CALC   = 2'b01,
        ST_FINISH = 2'b10
    } div_state_t;

    // ALU-select value that routes an instruction to the multi-cycle divider
    // instead of the combinational ALU paths.
    localparam logic [3:0] ALU_SEL_DIV = 4'b1011;

endpackage

// File: rtl/div_sub_stage.sv
// Ripple subtractor for one restoring-division step: t = s - {1'b0, d}.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   s      in  W+1  partial remainder shifted left with the next dividend bit
//   d      in  W    divisor
//   t      out W+1  difference, modulo 2^(W+1)
//   borrow out 1    high when s < d, i.e. the trial subtraction must be undone

// Single-bit full-adder cell shared with the rest of the datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module div_sub_stage #(
    parameter int W = 8
) (
    input  logic [W:0]   s,
    input  logic [W-1:0] d,
    output logic [W:0]   t,
    output logic         borrow
);

    // Two's-complement subtraction: add the inverted divisor with carry-in 1.
    logic [W:0]   d_inv;
    logic [W+1:0] carry;

    assign d_inv    = ~{1'b0, d};
    assign carry[0] = 1'b1;

    for (genvar i = 0; i <= W; i++) begin : g_bit
        full_adder u_fa (
            .a    (s[i]),
            .b    (d_inv[i]),
            .cin  (carry[i]),
            .sum  (t[i]),
            .cout (carry[i+1])
        );
    end

    // No carry out of the top bit means the unsigned subtraction wrapped.
    assign borrow = ~carry[W+1];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Latency: WIDTH cycles from the accepting edge to done; 1 cycle for divide-by-zero.
// Backpressure: start is ignored while busy; a new request may be accepted in the done cycle.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      request strobe, accepted in IDLE or FINISH
//   dividend     in   WIDTH  unsigned dividend, captured on the accepting edge
//   divisor      in   WIDTH  unsigned divisor, captured on the accepting edge
//   busy         out  1      high while iterating
//   done         out  1      one-cycle pulse when results are updated
//   quotient     out  WIDTH  result, held until the next request completes
//   remainder    out  WIDTH  result, held until the next request completes
//   div_by_zero  out  1      set with the results when the divisor was zero
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    div_state_t       state;
    div_state_t       state_nxt;

    logic [WIDTH:0]   r;      // remainder accumulator
    logic [WIDTH-1:0] q;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] d;      // captured divisor
    logic [CW-1:0]    cnt;    // iteration index within CALC

    logic             accept;
    logic             step;
    logic             last_step;

    logic [WIDTH:0]   s_val;
    logic [WIDTH:0]   t_val;
    logic             borrow;
    logic             fits;
    logic [WIDTH:0]   r_step;
    logic [WIDTH-1:0] q_step;

    // r only ever holds a value below d, so its top bit stays zero; it is
    // kept for the full-width accumulator but never feeds the next step.
    logic             unused_r_msb;
    assign unused_r_msb = r[WIDTH];

    // ------------------------------------------------------------------
    // One shift-subtract step
    // ------------------------------------------------------------------
    assign s_val = {r[WIDTH-1:0], q[WIDTH-1]};

    div_sub_stage #(
        .W (WIDTH)
    ) u_sub (
        .s      (s_val),
        .d      (d),
        .t      (t_val),
        .borrow (borrow)
    );

    // Because s < 2*d, the borrow coincides with the sign bit of t.
    assign fits   = ~borrow;
    assign r_step = fits ? t_val : s_val;
    assign q_step = {q[WIDTH-2:0], fits};

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        last_step = 1'b0;
        case (state)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    accept    = 1'b1;
                    // A zero divisor skips the loop and reports immediately.
                    state_nxt = (divisor == '0) ? ST_FINISH : ST_CALC;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    last_step = 1'b1;
                    state_nxt = ST_FINISH;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Both flags decode the state register directly, so they are glitch-free
    // and have no path from the request inputs.
    assign busy = (state == ST_CALC);
    assign done = (state == ST_FINISH);

    // ------------------------------------------------------------------
    // Working registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r   <= '0;
            q   <= '0;
            d   <= '0;
            cnt <= '0;
        end else if (accept) begin
            r   <= '0;
            q   <= dividend;
            d   <= divisor;
            cnt <= '0;
        end else if (step) begin
            r   <= r_step;
            q   <= q_step;
            cnt <= cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Result registers: only touched when a request completes, so they
    // hold through the following operation.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept && (divisor == '0)) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
        end else if (last_step) begin
            // Take the post-step values so results land with the FINISH entry.
            quotient    <= q_step;
            remainder   <= r_step[WIDTH-1:0];
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, with the zero-divisor convention.
    function automatic logic [W-1:0] ref_q(input int a, input int b);
        return (b == 0) ? {W{1'b1}} : W'(a / b);
    endfunction

    function automatic logic [W-1:0] ref_r(input int a, input int b);
        return (b == 0) ? W'(a) : W'(a % b);
    endfunction

    // Issue one request from idle and check every cycle until one after done.
    task automatic run_op(input int a, input int b);
        int           lat;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        lat = (b == 0) ? 0 : W;
        eq  = ref_q(a, b);
        er  = ref_r(a, b);
        @(negedge clk);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                chk("busy_calc", busy, 1);
                chk("done_early", done, 0);
            end else begin
                chk("done_pulse", done, 1);
                chk("busy_at_done", busy, 0);
                chk("quotient", quotient, eq);
                chk("remainder", remainder, er);
                chk("div_by_zero", div_by_zero, (b == 0) ? 1 : 0);
            end
        end
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after", busy, 0);
        chk("quotient_hold", quotient, eq);
        chk("remainder_hold", remainder, er);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_done", done, 0);

        // Directed values including the boundaries
        run_op(200, 7);
        run_op(255, 1);
        run_op(5, 9);
        run_op(255, 255);
        run_op(0, 3);
        run_op(100, 0);

        // START during CALC is ignored; START in FINISH is accepted
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            if (k == 2) begin
                start = 1'b1; dividend = 8'd9; divisor = 8'd2;
            end else if (k == 3) begin
                start = 1'b0; dividend = 8'd0; divisor = 8'd0;
            end
            if (k < W) begin
                chk("ign_busy", busy, 1);
                chk("ign_no_done", done, 0);
            end else begin
                chk("ign_done", done, 1);
                chk("ign_quotient", quotient, 28);
                chk("ign_remainder", remainder, 4);
                start = 1'b1; dividend = 8'd9; divisor = 8'd2;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0; dividend = 8'd77; divisor = 8'd0;
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            if (k < W) begin
                chk("b2b_busy", busy, 1);
                chk("b2b_no_done", done, 0);
                chk("b2b_prev_quotient_held", quotient, 28);
            end else begin
                chk("b2b_done", done, 1);
                chk("b2b_quotient", quotient, 4);
                chk("b2b_remainder", remainder, 1);
                chk("b2b_dbz", div_by_zero, 0);
            end
        end
        @(negedge clk);
        chk("b2b_done_one_cycle", done, 0);

        // Asynchronous reset in the middle of a calculation
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_quotient", quotient, 0);
        chk("arst_remainder", remainder, 0);
        chk("arst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("aborted_no_done", done, 0);
            chk("aborted_no_busy", busy, 0);
        end
        run_op(50, 6);

        // Randomised operands against the reference model
        for (int n = 0; n < 1000; n++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, 255));
            run_op(a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
